// File: rtl/kyber_ct_packer_if.sv
// Handshake and data bundle between kyber_pke_enc, the ciphertext packer and the byte consumer.
interface kyber_ct_packer_if #(
  parameter int IDX_W  = 16,
  parameter int BYTE_W = 11
);
  logic              start;
  logic              enc_done;
  logic              readout;
  logic [15:0]       kyber_dout_1;
  logic [15:0]       kyber_dout_2;
  logic [IDX_W-1:0]  kyber_out_index;
  logic [7:0]        ct_byte;
  logic              ct_valid;
  logic              ct_ready;
  logic              ct_last;
  logic [BYTE_W-1:0] ct_index;
  logic              busy;
  logic              ct_done;

  modport slave (
    input  start, enc_done, kyber_dout_1, kyber_dout_2, kyber_out_index, ct_ready,
    output readout, ct_byte, ct_valid, ct_last, ct_index, busy, ct_done
  );

  modport master (
    output start, enc_done, kyber_dout_1, kyber_dout_2, kyber_out_index, ct_ready,
    input  readout, ct_byte, ct_valid, ct_last, ct_index, busy, ct_done
  );
endinterface

// File: rtl/kyber_ct_packer.sv
// Captures the packed ciphertext from kyber_pke_enc into a slot RAM, then streams it out as
// little-endian bytes over valid/ready.
//   state      | meaning
//   S_IDLE     | waiting for start, all outputs quiet
//   S_WAIT_ENC | waiting for the encoder to report done
//   S_CAPTURE  | readout high, one slot written per in-range index
//   S_STREAM   | prime the RAM read, then emit bytes on handshakes
//   S_DONE     | one-cycle ct_done pulse
module kyber_ct_packer #(
  parameter int NUM_IDX = 272,
  parameter int IDX_W   = 16,
  parameter int BYTE_W  = 11
) (
  input  logic               i_clk,
  input  logic               i_reset,
  kyber_ct_packer_if.slave   io_ct
);
  localparam int                ADDR_W         = $clog2(NUM_IDX);
  localparam logic [IDX_W-1:0]  LAST_IDX       = IDX_W'(NUM_IDX - 1);
  localparam logic [IDX_W-1:0]  NUM_IDX_W      = IDX_W'(NUM_IDX);
  localparam logic [BYTE_W-1:0] LAST_BYTE      = BYTE_W'(4 * NUM_IDX - 1);
  localparam logic [BYTE_W-1:0] LAST_SLOT_BYTE = BYTE_W'(4 * (NUM_IDX - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ENC,
    S_CAPTURE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [31:0]       r_mem [NUM_IDX];
  logic [31:0]       r_rdata;
  logic              r_readout;
  logic [7:0]        r_ct_byte;
  logic              r_ct_valid;
  logic              r_ct_last;
  logic [BYTE_W-1:0] r_ct_index;
  logic              r_ct_done;
  logic              r_fill;

  logic              w_wr_en;
  logic              w_wr_last;
  logic              w_hs;
  logic              w_adv;
  logic              w_fill_rd;
  logic              w_pref_rd;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [BYTE_W-1:0] w_nxt_index;

  function automatic logic [7:0] f_sel(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  assign w_wr_en     = (r_state == S_CAPTURE) && r_readout && (io_ct.kyber_out_index < NUM_IDX_W);
  assign w_wr_last   = w_wr_en && (io_ct.kyber_out_index == LAST_IDX);
  assign w_hs        = r_ct_valid && io_ct.ct_ready;
  assign w_adv       = w_hs && !r_ct_last;
  assign w_nxt_index = r_ct_index + 1'b1;
  assign w_fill_rd   = (r_state == S_STREAM) && !r_ct_valid && !r_fill;
  // Next slot is fetched while lane 2 hands off, so lane 3 still sees the old word.
  assign w_pref_rd   = w_adv && (r_ct_index[1:0] == 2'd2) && (r_ct_index < LAST_SLOT_BYTE);
  assign w_rd_en     = w_fill_rd || w_pref_rd;
  assign w_rd_addr   = w_fill_rd ? '0 : ADDR_W'(r_ct_index[BYTE_W-1:2]) + ADDR_W'(1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (io_ct.start)       w_state_nxt = S_WAIT_ENC;
      S_WAIT_ENC: if (io_ct.enc_done)    w_state_nxt = S_CAPTURE;
      S_CAPTURE:  if (w_wr_last)         w_state_nxt = S_STREAM;
      S_STREAM:   if (w_hs && r_ct_last) w_state_nxt = S_DONE;
      S_DONE:                            w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[io_ct.kyber_out_index[ADDR_W-1:0]] <= {io_ct.kyber_dout_2, io_ct.kyber_dout_1};
    if (w_rd_en) r_rdata <= r_mem[w_rd_addr];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_readout  <= 1'b0;
      r_ct_byte  <= '0;
      r_ct_valid <= 1'b0;
      r_ct_last  <= 1'b0;
      r_ct_index <= '0;
      r_ct_done  <= 1'b0;
      r_fill     <= 1'b0;
    end else begin
      r_ct_done <= 1'b0;
      if (r_state == S_WAIT_ENC && io_ct.enc_done) r_readout <= 1'b1;
      else if (w_wr_last)                          r_readout <= 1'b0;

      if (r_state == S_STREAM) begin
        if (!r_ct_valid) begin
          if (!r_fill) begin
            r_fill <= 1'b1;
          end else begin
            r_fill     <= 1'b0;
            r_ct_valid <= 1'b1;
            r_ct_byte  <= f_sel(r_rdata, 2'd0);
            r_ct_index <= '0;
            r_ct_last  <= 1'b0;
          end
        end else if (w_hs) begin
          if (r_ct_last) begin
            r_ct_valid <= 1'b0;
            r_ct_last  <= 1'b0;
            r_ct_byte  <= '0;
            r_ct_index <= '0;
            r_ct_done  <= 1'b1;
          end else begin
            r_ct_index <= w_nxt_index;
            r_ct_byte  <= f_sel(r_rdata, w_nxt_index[1:0]);
            r_ct_last  <= (w_nxt_index == LAST_BYTE);
          end
        end
      end
    end
  end

  assign io_ct.readout  = r_readout;
  assign io_ct.ct_byte  = r_ct_byte;
  assign io_ct.ct_valid = r_ct_valid;
  assign io_ct.ct_last  = r_ct_last;
  assign io_ct.ct_index = r_ct_index;
  assign io_ct.ct_done  = r_ct_done;
  assign io_ct.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_kyber_ct_packer.sv
// Bench for kyber_ct_packer: drives capture sequences, collects the byte stream and compares it
// with bytes derived from a slot-array model of the ciphertext.
module tb_kyber_ct_packer;
  localparam int NUM_IDX = 272;
  localparam int IDX_W   = 16;
  localparam int BYTE_W  = 11;
  localparam int NB      = 4 * NUM_IDX;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kyber_ct_packer_if #(.IDX_W(IDX_W), .BYTE_W(BYTE_W)) ct_if ();
  kyber_ct_packer #(.NUM_IDX(NUM_IDX), .IDX_W(IDX_W), .BYTE_W(BYTE_W)) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .io_ct  (ct_if)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [NUM_IDX];
  int          ent_idx [$];
  logic [15:0] ent_d1  [$];
  logic [15:0] ent_d2  [$];
  logic [7:0]  q_byte  [$];
  int          q_index [$];

  int cap_viol, stall_viol, last_cnt, bad_last, done_cnt, first_valid_cyc, end_cyc;
  bit timed_out;

  function automatic logic [7:0] exp_byte(input int b);
    logic [31:0] w;
    w = ref_mem[b / 4];
    return w[8 * (b % 4) +: 8];
  endfunction

  function automatic int first_bad();
    for (int i = 0; i < q_byte.size(); i++)
      if (q_index[i] != i || q_byte[i] !== exp_byte(i)) return i;
    return -1;
  endfunction

  task automatic add_ent(input int idx, input logic [15:0] d1, input logic [15:0] d2);
    ent_idx.push_back(idx);
    ent_d1.push_back(d1);
    ent_d2.push_back(d2);
  endtask

  task automatic build_seq(input bit rnd);
    ent_idx.delete(); ent_d1.delete(); ent_d2.delete();
    for (int s = 0; s < NUM_IDX; s++)
      if (rnd) add_ent(s, 16'($urandom), 16'($urandom));
      else     add_ent(s, 16'(2 * s), 16'(2 * s + 1));
  endtask

  task automatic run_capture(input bit hold_enc, input bit start_pulse);
    int w;
    cap_viol = 0;
    @(negedge clk); ct_if.start = 1'b1;
    @(negedge clk); ct_if.start = 1'b0;
    repeat (2) @(negedge clk);
    ct_if.enc_done = 1'b1;
    w = 0;
    while (!ct_if.readout && w < 20) begin @(negedge clk); w++; end
    if (!ct_if.readout) cap_viol++;
    if (!hold_enc) ct_if.enc_done = 1'b0;
    for (int i = 0; i < ent_idx.size(); i++) begin
      if (!ct_if.readout) cap_viol++;
      ct_if.kyber_out_index = IDX_W'(ent_idx[i]);
      ct_if.kyber_dout_1    = ent_d1[i];
      ct_if.kyber_dout_2    = ent_d2[i];
      ct_if.start           = start_pulse && (i == 100);
      if (ent_idx[i] < NUM_IDX) ref_mem[ent_idx[i]] = {ent_d2[i], ent_d1[i]};
      @(negedge clk);
    end
    ct_if.start = 1'b0;
    ct_if.kyber_out_index = '1;
    if (ct_if.readout) cap_viol++;
  endtask

  // mode 0: ready high; 1: random ready with forced stalls; 2: ready high plus a stray start
  task automatic collect(input int mode, input int stop_at, input int max_cyc);
    bit prev_stall, fin, rdy, s3, s4, sl;
    logic [7:0] pb;
    int pi, stall_left;
    bit pl;
    q_byte.delete(); q_index.delete();
    stall_viol = 0; last_cnt = 0; bad_last = 0; done_cnt = 0;
    first_valid_cyc = -1; end_cyc = -1;
    prev_stall = 0; fin = 0; s3 = 0; s4 = 0; sl = 0; stall_left = 0;
    pb = '0; pi = 0; pl = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (ct_if.ct_done) begin done_cnt++; end_cyc = cyc; fin = 1; break; end
      if (prev_stall && (!ct_if.ct_valid || ct_if.ct_byte !== pb ||
                         int'(ct_if.ct_index) != pi || ct_if.ct_last !== pl))
        stall_viol++;
      if (ct_if.ct_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stop_at >= 0 && ct_if.ct_valid && int'(ct_if.ct_index) == stop_at) begin fin = 1; break; end
      if (ct_if.ct_valid && (ct_if.ct_last != (int'(ct_if.ct_index) == NB - 1))) bad_last++;
      rdy = 1'b1;
      if (mode == 1) begin
        if (ct_if.ct_valid && ct_if.ct_index == 3 && !s3) begin s3 = 1; stall_left = 5; end
        if (ct_if.ct_valid && ct_if.ct_index == 4 && !s4) begin s4 = 1; stall_left = 5; end
        if (ct_if.ct_valid && ct_if.ct_index == NB - 1 && !sl) begin sl = 1; stall_left = 5; end
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else rdy = 1'($urandom_range(0, 1));
      end
      ct_if.start    = (mode == 2) && (cyc == 300);
      ct_if.ct_ready = rdy;
      if (ct_if.ct_valid && rdy) begin
        q_byte.push_back(ct_if.ct_byte);
        q_index.push_back(int'(ct_if.ct_index));
        if (ct_if.ct_last) last_cnt++;
      end
      prev_stall = ct_if.ct_valid && !rdy;
      pb = ct_if.ct_byte; pi = int'(ct_if.ct_index); pl = ct_if.ct_last;
      @(negedge clk);
    end
    ct_if.start = 1'b0;
    timed_out = !fin;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ct_if.readout !== 1'b0)  begin errors++; $display("FAIL reset_readout got=%b want=0", ct_if.readout); end
    checks++; if (ct_if.ct_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", ct_if.ct_valid); end
    checks++; if (ct_if.ct_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got=%h want=00", ct_if.ct_byte); end
    checks++; if (ct_if.ct_last !== 1'b0)  begin errors++; $display("FAIL reset_last got=%b want=0", ct_if.ct_last); end
    checks++; if (ct_if.ct_index !== '0)   begin errors++; $display("FAIL reset_index got=%0d want=0", ct_if.ct_index); end
    checks++; if (ct_if.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", ct_if.busy); end
    checks++; if (ct_if.ct_done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b want=0", ct_if.ct_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    build_seq(0);
    run_capture(0, 0);
    checks++; if (cap_viol != 0) begin errors++; $display("FAIL normal_readout got=%0d want=0", cap_viol); end
    collect(0, -1, 3000);
    checks++; if (timed_out) begin errors++; $display("FAIL normal_timeout got=1 want=0"); end
    checks++; if (first_valid_cyc != 2) begin errors++; $display("FAIL normal_first_valid got=%0d want=2", first_valid_cyc); end
    checks++; if (end_cyc != NB + 2) begin errors++; $display("FAIL normal_done_latency got=%0d want=%0d", end_cyc, NB + 2); end
    checks++; if (q_byte.size() != NB) begin errors++; $display("FAIL normal_count got=%0d want=%0d", q_byte.size(), NB); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL normal_bytes first_bad_at=%0d want=-1", first_bad()); end
    checks++; if (last_cnt != 1 || bad_last != 0) begin errors++; $display("FAIL normal_last got=%0d/%0d want=1/0", last_cnt, bad_last); end
    @(negedge clk);
    checks++; if (ct_if.ct_done !== 1'b0 || ct_if.busy !== 1'b0) begin errors++; $display("FAIL normal_done_pulse got=%b/%b want=0/0", ct_if.ct_done, ct_if.busy); end
  endtask

  task automatic test_backpressure();
    build_seq(0);
    run_capture(0, 0);
    collect(1, -1, 20000);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got=1 want=0"); end
    checks++; if (q_byte.size() != NB) begin errors++; $display("FAIL bp_count got=%0d want=%0d", q_byte.size(), NB); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL bp_bytes first_bad_at=%0d want=-1", first_bad()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d want=0", stall_viol); end
    checks++; if (last_cnt != 1 || bad_last != 0) begin errors++; $display("FAIL bp_last got=%0d/%0d want=1/0", last_cnt, bad_last); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    @(negedge clk);
  endtask

  task automatic test_index_edges();
    ent_idx.delete(); ent_d1.delete(); ent_d2.delete();
    for (int s = 0; s < NUM_IDX; s++) begin
      if (s == 5) begin
        add_ent(5, 16'hAAAA, 16'h5555);
        add_ent(5, 16'h1234, 16'h0BCD);
        add_ent(300, 16'hDEAD, 16'hBEEF);
        add_ent(517, 16'hFFFF, 16'hFFFF);
      end else begin
        add_ent(s, 16'(2 * s), 16'(2 * s + 1));
      end
    end
    run_capture(0, 0);
    checks++; if (cap_viol != 0) begin errors++; $display("FAIL idx_capture_end got=%0d want=0", cap_viol); end
    collect(0, -1, 3000);
    checks++; if (q_byte.size() != NB) begin errors++; $display("FAIL idx_count got=%0d want=%0d", q_byte.size(), NB); end
    checks++; if (q_byte[20] !== 8'h34) begin errors++; $display("FAIL idx_byte20 got=%h want=34", q_byte[20]); end
    checks++; if (q_byte[21] !== 8'h12) begin errors++; $display("FAIL idx_byte21 got=%h want=12", q_byte[21]); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL idx_bytes first_bad_at=%0d want=-1", first_bad()); end
    @(negedge clk);
  endtask

  task automatic test_ignored();
    int extra_valid;
    build_seq(1);
    run_capture(1, 1);
    collect(2, -1, 3000);
    checks++; if (timed_out) begin errors++; $display("FAIL ign_timeout got=1 want=0"); end
    checks++; if (q_byte.size() != NB) begin errors++; $display("FAIL ign_count got=%0d want=%0d", q_byte.size(), NB); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL ign_bytes first_bad_at=%0d want=-1", first_bad()); end
    extra_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ct_if.ct_valid || ct_if.busy) extra_valid++;
    end
    checks++; if (extra_valid != 0) begin errors++; $display("FAIL ign_restart got=%0d want=0", extra_valid); end
    ct_if.enc_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    build_seq(1);
    run_capture(0, 0);
    collect(1, 500, 20000);
    checks++; if (timed_out) begin errors++; $display("FAIL rst_reach500 got=timeout want=reached"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ct_if.ct_valid !== 1'b0 || ct_if.ct_last !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b/%b want=0/0", ct_if.ct_valid, ct_if.ct_last); end
    checks++; if (ct_if.ct_index !== '0 || ct_if.ct_byte !== 8'h00) begin errors++; $display("FAIL rst_data got=%0d/%h want=0/00", ct_if.ct_index, ct_if.ct_byte); end
    checks++; if (ct_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", ct_if.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    ct_if.ct_ready = 1'b0;
    @(negedge clk);
    build_seq(1);
    run_capture(0, 0);
    collect(0, -1, 3000);
    checks++; if (timed_out) begin errors++; $display("FAIL rst_rerun_timeout got=1 want=0"); end
    checks++; if (q_index.size() == 0 || q_index[0] != 0) begin errors++; $display("FAIL rst_first_index got=%0d want=0", q_index.size() ? q_index[0] : -1); end
    checks++; if (q_byte.size() != NB) begin errors++; $display("FAIL rst_count got=%0d want=%0d", q_byte.size(), NB); end
    checks++; if (first_bad() != -1) begin errors++; $display("FAIL rst_bytes first_bad_at=%0d want=-1", first_bad()); end
  endtask

  initial begin
    ct_if.start           = 1'b0;
    ct_if.enc_done        = 1'b0;
    ct_if.ct_ready        = 1'b0;
    ct_if.kyber_dout_1    = '0;
    ct_if.kyber_dout_2    = '0;
    ct_if.kyber_out_index = '1;
    test_reset();
    test_normal();
    test_backpressure();
    test_index_edges();
    test_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
